// File: rtl/gsim_x_collector_if.sv
// Solution write bus and drain stream of the solution-vector collector.
// The solver/downstream side uses the master modport, the collector the slave modport.
interface gsim_x_collector_if #(
  parameter int DW = 32
);
  // Solver write side
  logic          i_x_wen;
  logic [8:0]    i_x_addr;
  logic [DW-1:0] i_x_data;
  // Drain stream side
  logic          o_out_valid;
  logic          i_out_ready;
  logic [8:0]    o_out_addr;
  logic [DW-1:0] o_out_data;
  logic          o_out_last;

  modport master (
    output i_x_wen, i_x_addr, i_x_data, i_out_ready,
    input  o_out_valid, o_out_addr, o_out_data, o_out_last
  );

  modport slave (
    input  i_x_wen, i_x_addr, i_x_data, i_out_ready,
    output o_out_valid, o_out_addr, o_out_data, o_out_last
  );
endinterface

// File: rtl/gsim_x_collector.sv
// Double-banked solution-vector collector: gathers 16 rows per matrix from the
// solver in any order, then drains each complete vector in row order over a
// valid/ready stream. Bank = low tag bit, so consecutive matrices ping-pong.
// Optional feature: define GSIM_XCOL_CHKSUM_EN to produce the XOR checksum of
// the last fully drained vector on o_chksum (otherwise o_chksum is tied to 0).
module gsim_x_collector #(
  parameter int DW = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  gsim_x_collector_if.slave   bus,
  output logic [4:0]          o_vec_cnt,
  output logic                o_err,
  output logic [DW-1:0]       o_chksum
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t        r_state;
  logic          r_bank;
  logic [3:0]    r_row;
  logic          r_valid;
  logic          r_last;
  logic [8:0]    r_addr;
  logic [DW-1:0] r_data;
  logic [4:0]    r_vec_cnt;
  logic          r_err;

  logic [4:0]    w_tag     [2];
  logic          w_full    [2];
  logic          w_acc     [2];
  logic          w_clr     [2];
  logic [DW-1:0] w_rd_data [2];

  logic          w_wbank;
  logic [3:0]    w_wrow;
  logic [4:0]    w_wtag;
  logic          w_hs;
  logic          w_done;
  logic          w_start_bank;
  logic          w_any_full;
  logic [3:0]    w_rd_row;

  assign w_wtag  = bus.i_x_addr[8:4];
  assign w_wbank = bus.i_x_addr[4];
  assign w_wrow  = bus.i_x_addr[3:0];

  assign w_hs         = r_valid && bus.i_out_ready;
  assign w_done       = w_hs && (r_row == 4'hF);
  assign w_any_full   = w_full[0] || w_full[1];
  // Bank 0 has priority when both banks are full at the same time.
  assign w_start_bank = w_full[0] ? 1'b0 : 1'b1;
  // Row fetched for the next output word: row 0 on vector start, else the next row.
  assign w_rd_row     = (r_state == S_DRAIN) ? (r_row + 4'd1) : 4'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      localparam bit BANK_ID = (gi != 0);

      logic [15:0]   r_mask;
      logic [4:0]    r_tag;
      logic          r_full;
      logic [DW-1:0] r_mem [16];
      logic          w_accept;

      // A row is taken only once per vector, only for the bank's current
      // matrix, and never while the bank is full (which covers draining).
      assign w_accept = bus.i_x_wen && (w_wbank == BANK_ID) && !r_full &&
                        !r_mask[w_wrow] &&
                        ((r_mask == 16'h0000) || (r_tag == w_wtag));

      // Row mask, matrix tag and full flag; the drain engine releases the bank.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_mask <= 16'h0000;
          r_tag  <= 5'd0;
          r_full <= 1'b0;
        end else if (w_clr[gi]) begin
          r_mask <= 16'h0000;
          r_full <= 1'b0;
        end else begin
          if (w_accept) begin
            r_mask[w_wrow] <= 1'b1;
            r_tag          <= w_wtag;
          end
          if (r_mask == 16'hFFFF) begin
            r_full <= 1'b1;
          end
        end
      end

      // Word storage; contents are qualified by the mask so no reset is needed.
      always_ff @(posedge i_clk) begin
        if (w_accept) begin
          r_mem[w_wrow] <= bus.i_x_data;
        end
      end

      assign w_rd_data[gi] = r_mem[w_rd_row];
      assign w_tag[gi]     = r_tag;
      assign w_full[gi]    = r_full;
      assign w_acc[gi]     = w_accept;
      assign w_clr[gi]     = w_done && (r_bank == BANK_ID);
    end
  endgenerate

  // Drain FSM with registered stream outputs; the bank read is captured here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_bank    <= 1'b0;
      r_row     <= 4'd0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_addr    <= 9'd0;
      r_data    <= '0;
      r_vec_cnt <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_full) begin
            r_state <= S_DRAIN;
            r_bank  <= w_start_bank;
            r_row   <= 4'd0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_addr  <= {w_tag[w_start_bank], 4'd0};
            r_data  <= w_rd_data[w_start_bank];
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (r_row == 4'hF) begin
              r_state   <= S_IDLE;
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_vec_cnt <= r_vec_cnt + 5'd1;
            end else begin
              r_row  <= r_row + 4'd1;
              r_last <= (r_row == 4'd14);
              r_addr <= {w_tag[r_bank], r_row + 4'd1};
              r_data <= w_rd_data[r_bank];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flag for any write that was dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (bus.i_x_wen && !w_acc[0] && !w_acc[1]) begin
      r_err <= 1'b1;
    end
  end

`ifdef GSIM_XCOL_CHKSUM_EN
  logic [DW-1:0] r_chk_acc;
  logic [DW-1:0] r_chksum;

  // Running XOR of the vector being drained, published after its last word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chk_acc <= '0;
      r_chksum  <= '0;
    end else if (r_state == S_IDLE) begin
      r_chk_acc <= '0;
    end else if (w_hs) begin
      r_chk_acc <= r_chk_acc ^ r_data;
      if (w_done) begin
        r_chksum <= r_chk_acc ^ r_data;
      end
    end
  end

  assign o_chksum = r_chksum;
`else
  assign o_chksum = '0;
`endif

  assign bus.o_out_valid = r_valid;
  assign bus.o_out_addr  = r_addr;
  assign bus.o_out_data  = r_data;
  assign bus.o_out_last  = r_last;
  assign o_vec_cnt       = r_vec_cnt;
  assign o_err           = r_err;

endmodule

// File: tb/tb_gsim_x_collector.sv
// Self-checking bench for gsim_x_collector: directed scenarios followed by
// randomized vectors, compared against a per-vector expectation model.
module tb_gsim_x_collector;
  localparam int DW = 32;

  typedef struct {
    logic [8:0]    a;
    logic [DW-1:0] d;
    logic          l;
    int            c;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    vec_cnt;
  logic          err;
  logic [DW-1:0] chksum;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            v_seen   = 0;
  word_t         q[$];

  gsim_x_collector_if #(.DW(DW)) bus ();

  gsim_x_collector #(.DW(DW)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_vec_cnt (vec_cnt),
    .o_err     (err),
    .o_chksum  (chksum)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  // Stream monitor: records accepted words and checks that a stalled word holds.
  initial begin
    logic          hold;
    logic [8:0]    h_addr;
    logic [DW-1:0] h_data;
    logic          h_last;
    word_t         w;
    hold = 1'b0;
    h_addr = '0; h_data = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_stable", {bus.o_out_valid, bus.o_out_addr, bus.o_out_data, bus.o_out_last} ===
                           {1'b1, h_addr, h_data, h_last});
      end
      if (bus.o_out_valid === 1'b1) v_seen++;
      if (bus.o_out_valid === 1'b1 && bus.i_out_ready === 1'b1 && rst === 1'b0) begin
        w.a = bus.o_out_addr; w.d = bus.o_out_data; w.l = bus.o_out_last; w.c = cyc;
        q.push_back(w);
      end
      hold   = (bus.o_out_valid === 1'b1) && (bus.i_out_ready === 1'b0) && (rst === 1'b0);
      h_addr = bus.o_out_addr;
      h_data = bus.o_out_data;
      h_last = bus.o_out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] tag, input logic [3:0] row, input logic [DW-1:0] d);
    bus.i_x_wen  = 1'b1;
    bus.i_x_addr = {tag, row};
    bus.i_x_data = d;
    step();
    bus.i_x_wen  = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggles, other: random ready
  task automatic drain(input int n, input int mode);
    int k;
    k = 0;
    while (q.size() < n && k < 600) begin
      case (mode)
        0:       bus.i_out_ready = 1'b1;
        1:       bus.i_out_ready = !bus.i_out_ready;
        default: bus.i_out_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      k++;
    end
    chk("drain_done", q.size() >= n);
  endtask

  // Pops one vector and compares it against the expected tag and row data.
  task automatic check_vec(input logic [4:0] tag, input logic [DW-1:0] exp_d[16],
                           output int first_c, output int last_c);
    word_t w;
    first_c = 0;
    last_c  = 0;
    for (int i = 0; i < 16; i++) begin
      if (q.size() == 0) begin
        chk("vec_missing_word", q.size() > 0);
        return;
      end
      w = q.pop_front();
      if (i == 0)  first_c = w.c;
      if (i == 15) last_c  = w.c;
      chk("vec_word", {w.a, w.d, w.l} === {tag, 4'(i), exp_d[i], (i == 15)});
    end
  endtask

  function automatic logic [DW-1:0] exp_chk(input logic [DW-1:0] v[16]);
    logic [DW-1:0] x;
    x = '0;
`ifdef GSIM_XCOL_CHKSUM_EN
    foreach (v[i]) x = x ^ v[i];
`endif
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d0[16];
    logic [DW-1:0] d1[16];
    logic [4:0]    exp_cnt;
    logic [4:0]    tag;
    int            lat, f0, l0, f1, l1, vs, k;
    int            perm[16];
    word_t         w;

    bus.i_x_wen = 1'b0; bus.i_x_addr = '0; bus.i_x_data = '0; bus.i_out_ready = 1'b0;
    exp_cnt = 5'd0;

    // ---- reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.o_out_valid === 1'b0);
    chk("rst_last",  bus.o_out_last === 1'b0);
    chk("rst_addr",  bus.o_out_addr === 9'd0);
    chk("rst_data",  bus.o_out_data === 32'd0);
    chk("rst_cnt",   vec_cnt === 5'd0);
    chk("rst_err",   err === 1'b0);
    chk("rst_chk",   chksum === 32'd0);
    step();

    // ---- matrix 0, in-order rows, ready high, latency from 16th write
    bus.i_out_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      d0[r] = DW'(r + 1);
      wr(5'd0, 4'(r), d0[r]);
    end
    lat = 0;
    @(negedge clk);
    while (bus.o_out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat == 2);
    drain(16, 0);
    check_vec(5'd0, d0, f0, l0);
    step(); step();
    exp_cnt++;
    chk("m0_cnt", vec_cnt === exp_cnt);
    chk("m0_chksum", chksum === exp_chk(d0));

    // ---- matrix 1, reverse rows, ready toggling
    bus.i_out_ready = 1'b0;
    for (int r = 15; r >= 0; r--) begin
      d1[r] = DW'(32'h10 + r);
      wr(5'd1, 4'(r), d1[r]);
    end
    drain(16, 1);
    check_vec(5'd1, d1, f1, l1);
    step(); step();
    exp_cnt++;
    chk("m1_cnt", vec_cnt === exp_cnt);
    chk("m1_chksum", chksum === exp_chk(d1));
    chk("m1_err", err === 1'b0);

    // ---- matrices 2 and 3 concurrently, ready low, then write to busy bank 0
    do_reset();
    exp_cnt = 5'd0;
    bus.i_out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      d0[r] = $urandom;
      d1[r] = $urandom;
      wr(5'd2, 4'(r), d0[r]);
      wr(5'd3, 4'(r), d1[r]);
    end
    repeat (20) step();
    @(negedge clk);
    chk("m23_err_clean", err === 1'b0);
    chk("m23_first_valid", bus.o_out_valid === 1'b1);
    chk("m23_first_addr", bus.o_out_addr === {5'd2, 4'd0});
    step();
    wr(5'd4, 4'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("m4_drop_err", err === 1'b1);
    chk("m4_drop_addr", bus.o_out_addr === {5'd2, 4'd0});
    step();
    drain(32, 0);
    check_vec(5'd2, d0, f0, l0);
    check_vec(5'd3, d1, f1, l1);
    chk("bubble", (f1 - l0) == 2);
    step(); step();
    exp_cnt = 5'd2;
    chk("m23_cnt", vec_cnt === exp_cnt);
    chk("m23_chksum", chksum === exp_chk(d1));
    vs = v_seen;
    repeat (10) step();
    chk("m4_no_output", (v_seen - vs) == 0);
    chk("m4_no_words", q.size() == 0);

    // ---- matrix 2 row 3 written twice: second write dropped
    do_reset();
    exp_cnt = 5'd0;
    bus.i_out_ready = 1'b1;
    for (int r = 0; r < 16; r++) d0[r] = $urandom;
    wr(5'd2, 4'd3, d0[3]);
    wr(5'd2, 4'd3, ~d0[3]);
    @(negedge clk);
    chk("dup_err", err === 1'b1);
    for (int r = 0; r < 16; r++) begin
      if (r != 3) wr(5'd2, 4'(r), d0[r]);
    end
    drain(16, 0);
    check_vec(5'd2, d0, f0, l0);
    step(); step();
    exp_cnt++;
    chk("dup_cnt", vec_cnt === exp_cnt);

    // ---- reset in the middle of a drain (row 7 on the stream)
    bus.i_out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      d1[r] = $urandom;
      wr(5'd5, 4'(r), d1[r]);
    end
    k = 0;
    while (bus.o_out_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("m5_valid_wait", bus.o_out_valid === 1'b1);
    repeat (7) begin
      bus.i_out_ready = 1'b1;
      step();
      bus.i_out_ready = 1'b0;
    end
    @(negedge clk);
    chk("m5_row7_addr", bus.o_out_addr === {5'd5, 4'd7});
    chk("m5_row7_data", bus.o_out_data === d1[7]);
    for (int i = 0; i < 7; i++) begin
      if (q.size() > 0) begin
        w = q.pop_front();
        chk("m5_pre_word", {w.a, w.d} === {5'd5, 4'(i), d1[i]});
      end
    end
    step();
    do_reset();
    @(negedge clk);
    chk("midrst_valid", bus.o_out_valid === 1'b0);
    chk("midrst_cnt", vec_cnt === 5'd0);
    chk("midrst_err", err === 1'b0);
    chk("midrst_chk", chksum === 32'd0);
    step();
    bus.i_out_ready = 1'b1;
    vs = v_seen;
    repeat (30) step();
    chk("midrst_quiet", (v_seen - vs) == 0);
    chk("midrst_no_words", q.size() == 0);

    // ---- randomized vectors: random tag, row order, gaps and ready pattern
    exp_cnt = 5'd0;
    for (int v = 0; v < 34; v++) begin
      tag = 5'($urandom_range(0, 31));
      for (int i = 0; i < 16; i++) begin
        perm[i] = i;
        d0[i]   = $urandom;
      end
      for (int i = 15; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 16; i++) begin
        bus.i_out_ready = 1'($urandom_range(0, 1));
        wr(tag, 4'(perm[i]), d0[perm[i]]);
        repeat ($urandom_range(0, 2)) step();
      end
      drain(16, 2);
      check_vec(tag, d0, f0, l0);
      step(); step();
      exp_cnt++;
      chk("rnd_cnt", vec_cnt === exp_cnt);
      chk("rnd_chksum", chksum === exp_chk(d0));
    end
    chk("rnd_err", err === 1'b0);
    chk("rnd_leftover", q.size() == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
